two_way_stream_demultiplexer: RTL and testbench

Routes a single valid/ready input stream to one of two output streams, chosen per beat by a select bit. Each output is decoupled by its own two-entry buffer and carries a delivered-beat counter. It is the distributing counterpart of the two-way multiplexer and is used wherever one producer feeds two consumers, for example a result bus split between a register-file write port and a forwarding path.

---
 rtl/two_way_stream_demultiplexer_pkg.sv | 19 +
 rtl/two_way_stream_demultiplexer_if.sv | 37 +++
 rtl/two_way_stream_demultiplexer_buffer.sv | 80 ++++++++
 rtl/two_way_stream_demultiplexer.sv | 85 ++++++++
 tb/tb_two_way_stream_demultiplexer.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/two_way_stream_demultiplexer_pkg.sv
// Shared constants and types for the two-way stream demultiplexer.
package two_way_stream_demultiplexer_pkg;

  // Entries held by each output decoupling buffer.
  localparam int STREAM_BUFFER_DEPTH = 2;

  // Buffer occupancy doubles as the buffer control state.
  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_state_e;

  // A buffer can take a beat while its occupancy is below the depth.
  function automatic logic has_room(occ_state_e occ);
    return int'(occ) < STREAM_BUFFER_DEPTH;
  endfunction

endpackage

// File: rtl/two_way_stream_demultiplexer_if.sv
// Stream bundle of the demultiplexer: one input stream, two output streams
// with their delivered-beat counters.
interface two_way_stream_demultiplexer_if #(
  parameter int DATA_WIDTH  = 8,
  parameter int COUNT_WIDTH = 16
);

  logic [DATA_WIDTH-1:0]  in_data;
  logic                   in_select;
  logic                   in_valid;
  logic                   in_ready;

  logic [DATA_WIDTH-1:0]  out1_data;
  logic                   out1_valid;
  logic                   out1_ready;
  logic [COUNT_WIDTH-1:0] out1_count;

  logic [DATA_WIDTH-1:0]  out2_data;
  logic                   out2_valid;
  logic                   out2_ready;
  logic [COUNT_WIDTH-1:0] out2_count;

  // Producer and consumers: drive the input stream and the output readies.
  modport master (
    output in_data, in_select, in_valid, out1_ready, out2_ready,
    input  in_ready, out1_data, out1_valid, out1_count,
           out2_data, out2_valid, out2_count
  );

  // Demultiplexer side.
  modport slave (
    input  in_data, in_select, in_valid, out1_ready, out2_ready,
    output in_ready, out1_data, out1_valid, out1_count,
           out2_data, out2_valid, out2_count
  );

endinterface

// File: rtl/two_way_stream_demultiplexer_buffer.sv
// Two-entry FIFO decoupling one output stream. The head entry is always the
// presented payload; it keeps its last value after the buffer drains.
module stream_buffer_2entry
  import two_way_stream_demultiplexer_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] head_data,
  output logic                  valid,
  output logic                  not_full
);

  occ_state_e            state_q;
  occ_state_e            state_d;
  logic [DATA_WIDTH-1:0] head_q;
  logic [DATA_WIDTH-1:0] tail_q;
  logic                  push_en;
  logic                  pop_en;

  // A push into a full buffer or a pop from an empty one is ignored.
  assign push_en   = push && not_full;
  assign pop_en    = pop && valid;
  assign head_data = head_q;

  // Occupancy state register.
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: state is always written with <= so every flop samples the
    // pre-edge values; blocking here would create order-dependent races.
    if (!reset_n) state_q <= OCC_EMPTY;
    else          state_q <= state_d;
  end

  // Next occupancy from the push/pop pair.
  always_comb begin
    // NOTE: default first so no path leaves state_d unassigned (no latch).
    state_d = state_q;
    unique case (state_q)
      OCC_EMPTY: if (push_en) state_d = OCC_ONE;
      OCC_ONE: begin
        if (push_en && !pop_en)      state_d = OCC_FULL;
        else if (pop_en && !push_en) state_d = OCC_EMPTY;
      end
      OCC_FULL:  if (pop_en) state_d = OCC_ONE;
      default:   state_d = OCC_EMPTY;
    endcase
  end

  // Stream flags decoded from occupancy.
  always_comb begin
    valid    = (state_q != OCC_EMPTY);
    not_full = has_room(state_q);
  end

  // Entry storage: head is presented, tail waits behind it.
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: the two entries are reset because the presented payload must
    // read zero after reset; a deeper RAM-style buffer would skip this.
    if (!reset_n) begin
      head_q <= '0;
      tail_q <= '0;
    end else begin
      unique case (state_q)
        OCC_EMPTY: if (push_en) head_q <= push_data;
        OCC_ONE: begin
          // With a simultaneous pop the new beat replaces the leaving head.
          if (push_en && pop_en) head_q <= push_data;
          else if (push_en)      tail_q <= push_data;
        end
        OCC_FULL:  if (pop_en) head_q <= tail_q;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/two_way_stream_demultiplexer.sv
// Routes one valid/ready stream to out1 (select=1) or out2 (select=0). Each
// output has its own two-entry buffer and a wrapping delivered-beat counter.
module two_way_stream_demultiplexer
  import two_way_stream_demultiplexer_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                          clk,
  input  logic                          reset_n,
  two_way_stream_demultiplexer_if.slave bus
);

  logic [DATA_WIDTH-1:0]  head1;
  logic [DATA_WIDTH-1:0]  head2;
  logic                   valid1;
  logic                   valid2;
  logic                   not_full1;
  logic                   not_full2;
  logic                   in_ready;
  logic                   accept;
  logic                   push1;
  logic                   push2;
  logic                   pop1;
  logic                   pop2;
  logic [COUNT_WIDTH-1:0] count1_q;
  logic [COUNT_WIDTH-1:0] count2_q;

  // Input routing: ready depends only on select and registered occupancy,
  // never on the output readies.
  always_comb begin
    in_ready = bus.in_select ? not_full1 : not_full2;
    accept   = bus.in_valid && in_ready;
    push1    = accept && bus.in_select;
    push2    = accept && !bus.in_select;
  end

  // Output handshakes.
  always_comb begin
    pop1 = valid1 && bus.out1_ready;
    pop2 = valid2 && bus.out2_ready;
  end

  stream_buffer_2entry #(.DATA_WIDTH(DATA_WIDTH)) u_buffer1 (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (push1),
    .push_data (bus.in_data),
    .pop       (pop1),
    .head_data (head1),
    .valid     (valid1),
    .not_full  (not_full1)
  );

  stream_buffer_2entry #(.DATA_WIDTH(DATA_WIDTH)) u_buffer2 (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (push2),
    .push_data (bus.in_data),
    .pop       (pop2),
    .head_data (head2),
    .valid     (valid2),
    .not_full  (not_full2)
  );

  // Delivered-beat counters, wrapping modulo 2^COUNT_WIDTH.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count1_q <= '0;
      count2_q <= '0;
    end else begin
      if (pop1) count1_q <= count1_q + 1'b1;
      if (pop2) count2_q <= count2_q + 1'b1;
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.out1_data  = head1;
  assign bus.out1_valid = valid1;
  assign bus.out1_count = count1_q;
  assign bus.out2_data  = head2;
  assign bus.out2_valid = valid2;
  assign bus.out2_count = count2_q;

endmodule

// File: tb/tb_two_way_stream_demultiplexer.sv
// Self-checking bench: a table of per-cycle vectors for routing,
// backpressure and push-and-pop, then hand sequences for reset with full
// buffers, long streaming and counter wrap on a narrow-counter instance.
module tb_two_way_stream_demultiplexer;

  localparam int DW   = 8;
  localparam int CW   = 16;
  localparam int CW_W = 4;

  logic clk = 1'b0;
  logic reset_n;

  always #5 clk = ~clk;

  two_way_stream_demultiplexer_if #(.DATA_WIDTH(DW), .COUNT_WIDTH(CW))   bus ();
  two_way_stream_demultiplexer_if #(.DATA_WIDTH(DW), .COUNT_WIDTH(CW_W)) bus_w ();

  two_way_stream_demultiplexer #(.DATA_WIDTH(DW), .COUNT_WIDTH(CW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  two_way_stream_demultiplexer #(.DATA_WIDTH(DW), .COUNT_WIDTH(CW_W)) dut_w (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus_w.slave)
  );

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic          v;
    logic          s;
    logic [DW-1:0] d;
    logic          r1;
    logic          r2;
    logic          e_rdy;
    logic          e_v1;
    logic [DW-1:0] e_d1;
    logic          e_v2;
    logic [DW-1:0] e_d2;
    int            e_c1;
    int            e_c2;
  } vec_t;

  localparam int NVEC = 14;
  vec_t vecs[NVEC];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(logic v, logic s, logic [DW-1:0] d, logic r1, logic r2,
                              logic e_rdy, logic e_v1, logic [DW-1:0] e_d1,
                              logic e_v2, logic [DW-1:0] e_d2, int e_c1, int e_c2);
    vec_t t;
    t.v = v; t.s = s; t.d = d; t.r1 = r1; t.r2 = r2;
    t.e_rdy = e_rdy; t.e_v1 = e_v1; t.e_d1 = e_d1;
    t.e_v2 = e_v2; t.e_d2 = e_d2; t.e_c1 = e_c1; t.e_c2 = e_c2;
    return t;
  endfunction

  task automatic set_in(input logic v, input logic s, input logic [DW-1:0] d,
                        input logic r1, input logic r2);
    bus.in_valid   = v;
    bus.in_select  = s;
    bus.in_data    = d;
    bus.out1_ready = r1;
    bus.out2_ready = r2;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // in_valid sel data r1 r2 | in_ready v1 d1 v2 d2 c1 c2 (after the edge)
    // Routing
    vecs[0]  = mk(1, 1, 8'h11, 1, 1,  1, 1, 8'h11, 0, 8'h00, 0, 0);
    vecs[1]  = mk(1, 0, 8'h22, 1, 1,  1, 0, 8'h00, 1, 8'h22, 1, 0);
    vecs[2]  = mk(0, 0, 8'h00, 1, 1,  1, 0, 8'h00, 0, 8'h00, 1, 1);
    // Backpressure on out1, out2 still accepts
    vecs[3]  = mk(1, 1, 8'hA0, 0, 1,  1, 1, 8'hA0, 0, 8'h00, 1, 1);
    vecs[4]  = mk(1, 1, 8'hA1, 0, 1,  1, 1, 8'hA0, 0, 8'h00, 1, 1);
    vecs[5]  = mk(1, 0, 8'hB0, 0, 0,  1, 1, 8'hA0, 1, 8'hB0, 1, 1);
    vecs[6]  = mk(1, 1, 8'hA2, 0, 0,  0, 1, 8'hA0, 1, 8'hB0, 1, 1);
    // Release out1: ready stays low this cycle (occupancy still 2)
    vecs[7]  = mk(1, 1, 8'hA2, 1, 0,  0, 1, 8'hA1, 1, 8'hB0, 2, 1);
    vecs[8]  = mk(1, 1, 8'hA2, 1, 0,  1, 1, 8'hA2, 1, 8'hB0, 3, 1);
    vecs[9]  = mk(0, 1, 8'h00, 1, 1,  1, 0, 8'h00, 0, 8'h00, 4, 2);
    // Ready without valid leaves counts alone
    vecs[10] = mk(0, 0, 8'h00, 1, 1,  1, 0, 8'h00, 0, 8'h00, 4, 2);
    // Push-and-pop at occupancy 1
    vecs[11] = mk(1, 1, 8'h44, 0, 0,  1, 1, 8'h44, 0, 8'h00, 4, 2);
    vecs[12] = mk(1, 1, 8'h55, 1, 0,  1, 1, 8'h55, 0, 8'h00, 5, 2);
    vecs[13] = mk(0, 1, 8'h00, 1, 0,  1, 0, 8'h00, 0, 8'h00, 6, 2);

    set_in(0, 0, '0, 0, 0);
    bus_w.in_valid   = 1'b0;
    bus_w.in_select  = 1'b0;
    bus_w.in_data    = '0;
    bus_w.out1_ready = 1'b0;
    bus_w.out2_ready = 1'b0;

    // Power-on reset
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out1_valid", bus.out1_valid, 0);
    check("rst_out2_valid", bus.out2_valid, 0);
    check("rst_out1_data",  bus.out1_data,  0);
    check("rst_out2_data",  bus.out2_data,  0);
    check("rst_out1_count", bus.out1_count, 0);
    check("rst_out2_count", bus.out2_count, 0);
    bus.in_select = 1'b1;
    #1 check("rst_in_ready_sel1", bus.in_ready, 1);
    bus.in_select = 1'b0;
    #1 check("rst_in_ready_sel0", bus.in_ready, 1);
    reset_n = 1'b1;
    tick();

    // Table-driven vectors: each entry is one clock cycle.
    for (int i = 0; i < NVEC; i++) begin
      set_in(vecs[i].v, vecs[i].s, vecs[i].d, vecs[i].r1, vecs[i].r2);
      #1 check($sformatf("v%0d_in_ready", i), bus.in_ready, vecs[i].e_rdy);
      tick();
      check($sformatf("v%0d_out1_valid", i), bus.out1_valid, vecs[i].e_v1);
      check($sformatf("v%0d_out2_valid", i), bus.out2_valid, vecs[i].e_v2);
      if (vecs[i].e_v1) check($sformatf("v%0d_out1_data", i), bus.out1_data, vecs[i].e_d1);
      if (vecs[i].e_v2) check($sformatf("v%0d_out2_data", i), bus.out2_data, vecs[i].e_d2);
      check($sformatf("v%0d_out1_count", i), bus.out1_count, vecs[i].e_c1);
      check($sformatf("v%0d_out2_count", i), bus.out2_count, vecs[i].e_c2);
    end
    // Drained output keeps presenting its last head
    check("out1_data_hold", bus.out1_data, 8'h55);

    // Fill both buffers, then reset mid-stream
    set_in(1, 1, 8'hC0, 0, 0); tick();
    set_in(1, 1, 8'hC1, 0, 0); tick();
    set_in(1, 0, 8'hD0, 0, 0); tick();
    set_in(1, 0, 8'hD1, 0, 0); tick();
    set_in(0, 1, 8'h00, 0, 0);
    #1 check("full_in_ready_sel1", bus.in_ready, 0);
    bus.in_select = 1'b0;
    #1 check("full_in_ready_sel0", bus.in_ready, 0);
    check("full_out1_data", bus.out1_data, 8'hC0);
    check("full_out2_data", bus.out2_data, 8'hD0);
    reset_n = 1'b0;
    #1;
    check("arst_out1_valid", bus.out1_valid, 0);
    check("arst_out2_valid", bus.out2_valid, 0);
    check("arst_out1_count", bus.out1_count, 0);
    tick();
    check("mrst_out1_valid", bus.out1_valid, 0);
    check("mrst_out2_valid", bus.out2_valid, 0);
    check("mrst_out1_data",  bus.out1_data,  0);
    check("mrst_out2_data",  bus.out2_data,  0);
    check("mrst_out1_count", bus.out1_count, 0);
    check("mrst_out2_count", bus.out2_count, 0);
    check("mrst_in_ready",   bus.in_ready,   1);
    reset_n = 1'b1;
    tick();
    check("post_rst_out2_valid", bus.out2_valid, 0);

    // Streaming: 100 back-to-back beats to out2
    for (int i = 0; i < 100; i++) begin
      set_in(1, 0, DW'(i + 1), 0, 1);
      #1 check($sformatf("stream%0d_in_ready", i), bus.in_ready, 1);
      tick();
      check($sformatf("stream%0d_out2_valid", i), bus.out2_valid, 1);
      check($sformatf("stream%0d_out2_data", i), bus.out2_data, DW'(i + 1));
    end
    set_in(0, 0, '0, 0, 1);
    tick();
    check("stream_out2_valid_end", bus.out2_valid, 0);
    check("stream_out2_count", bus.out2_count, 100);
    check("stream_out1_count", bus.out1_count, 0);

    // Counter wrap on the 4-bit instance: 17 beats on out1
    for (int i = 0; i < 17; i++) begin
      bus_w.in_valid   = 1'b1;
      bus_w.in_select  = 1'b1;
      bus_w.in_data    = DW'(i);
      bus_w.out1_ready = 1'b1;
      tick();
    end
    bus_w.in_valid = 1'b0;
    tick();
    check("wrap_out1_valid", bus_w.out1_valid, 0);
    check("wrap_out1_count", bus_w.out1_count, 1);
    check("wrap_out2_count", bus_w.out2_count, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
